// File: rtl/mem_req_arbiter.sv
// Two-requester (icache / dcache) arbiter onto a single memory request port.
// Tracks outstanding reads by TID and outstanding stores by count.
module mem_req_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TID_W      = 2,
  parameter int MAX_STORES = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  input  logic              dc_req_valid_i,
  input  logic              dc_req_we_i,
  input  logic              dc_req_nc_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [DATA_W-1:0] dc_req_wdata_i,
  output logic              dc_req_ready_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [TID_W-1:0]  mem_req_tid_o,
  input  logic              mem_rsp_valid_i,
  input  logic              mem_rsp_we_i,
  input  logic [TID_W-1:0]  mem_rsp_tid_i,
  input  logic [DATA_W-1:0] mem_rsp_rdata_i,
  output logic              ic_rsp_valid_o,
  output logic [DATA_W-1:0] ic_rsp_rdata_o,
  output logic              dc_rsp_valid_o,
  output logic              dc_rsp_we_o,
  output logic [DATA_W-1:0] dc_rsp_rdata_o,
  output logic [2:0]        stores_pending_o
);

  localparam int         NTID        = 1 << TID_W;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;
  localparam logic [2:0] STORE_LIMIT = 3'(MAX_STORES);

  logic [1:0]      state;
  logic [NTID-1:0] tid_busy;
  logic [NTID-1:0] tid_owner_dc;
  logic [NTID-1:0] tid_busy_nxt;
  logic [2:0]      stores_pending;
  logic            rr_dc;

  logic             tid_avail;
  logic [TID_W-1:0] free_tid;
  logic             ic_elig;
  logic             dc_elig;
  logic             in_idle;
  logic             drain_req;
  logic             grant_ic;
  logic             grant_dc;
  logic             grant_read;
  logic             grant_write;
  logic             rsp_read;
  logic             rsp_ack;
  logic             rsp_owner_dc;

  function automatic logic [TID_W-1:0] lowest_free(input logic [NTID-1:0] busy);
    logic [TID_W-1:0] sel;
    sel = '0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (!busy[i]) sel = TID_W'(i);
    end
    return sel;
  endfunction

  // Store counter never wraps below zero; callers only raise inc below the limit.
  function automatic logic [2:0] next_count(input logic [2:0] cnt, input logic inc,
                                            input logic dec);
    logic [2:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + 3'd1;
    else if (dec && !inc && cnt != 3'd0) res = cnt - 3'd1;
    return res;
  endfunction

  always_comb begin
    tid_avail    = ~&tid_busy;
    free_tid     = lowest_free(tid_busy);
    ic_elig      = ic_req_valid_i && tid_avail;
    dc_elig      = dc_req_valid_i &&
                   (dc_req_we_i ? (stores_pending < STORE_LIMIT)
                                : (tid_avail && (!dc_req_nc_i || stores_pending == 3'd0)));
    in_idle      = (state == S_IDLE) && !rst_i;
    // A non-cacheable read must wait for all earlier stores; nobody is granted meanwhile.
    drain_req    = in_idle && dc_req_valid_i && !dc_req_we_i && dc_req_nc_i &&
                   (stores_pending != 3'd0);
    grant_ic     = in_idle && !drain_req && ic_elig && (!dc_elig || !rr_dc);
    grant_dc     = in_idle && !drain_req && dc_elig && !grant_ic;
    grant_read   = grant_ic || (grant_dc && !dc_req_we_i);
    grant_write  = grant_dc && dc_req_we_i;
    rsp_read     = mem_rsp_valid_i && !mem_rsp_we_i && tid_busy[mem_rsp_tid_i];
    rsp_ack      = mem_rsp_valid_i && mem_rsp_we_i && (stores_pending != 3'd0);
    rsp_owner_dc = tid_owner_dc[mem_rsp_tid_i];
  end

  always_comb begin
    tid_busy_nxt = tid_busy;
    if (rsp_read)   tid_busy_nxt[mem_rsp_tid_i] = 1'b0;
    if (grant_read) tid_busy_nxt[free_tid]      = 1'b1;
  end

  assign ic_req_ready_o   = grant_ic;
  assign dc_req_ready_o   = grant_dc;
  assign stores_pending_o = stores_pending;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      tid_busy        <= '0;
      tid_owner_dc    <= '0;
      stores_pending  <= 3'd0;
      rr_dc           <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_we_o    <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_wdata_o <= '0;
      mem_req_tid_o   <= '0;
      ic_rsp_valid_o  <= 1'b0;
      ic_rsp_rdata_o  <= '0;
      dc_rsp_valid_o  <= 1'b0;
      dc_rsp_we_o     <= 1'b0;
      dc_rsp_rdata_o  <= '0;
    end else begin
      tid_busy       <= tid_busy_nxt;
      stores_pending <= next_count(stores_pending, grant_write, rsp_ack);
      if (grant_read) tid_owner_dc[free_tid] <= grant_dc;
      if (grant_ic || grant_dc) rr_dc <= grant_ic;

      // Request side: grant in IDLE, hold payload through ISSUE until accepted.
      case (state)
        S_IDLE: begin
          if (drain_req) begin
            state <= S_DRAIN;
          end else if (grant_ic) begin
            state           <= S_ISSUE;
            mem_req_valid_o <= 1'b1;
            mem_req_we_o    <= 1'b0;
            mem_req_addr_o  <= ic_req_addr_i;
            mem_req_wdata_o <= '0;
            mem_req_tid_o   <= free_tid;
          end else if (grant_dc) begin
            state           <= S_ISSUE;
            mem_req_valid_o <= 1'b1;
            mem_req_we_o    <= dc_req_we_i;
            mem_req_addr_o  <= dc_req_addr_i;
            mem_req_wdata_o <= dc_req_we_i ? dc_req_wdata_i : '0;
            mem_req_tid_o   <= dc_req_we_i ? '0 : free_tid;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready_i) begin
            state           <= S_IDLE;
            mem_req_valid_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (stores_pending == 3'd0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Response side: route by TID owner, one cycle of latency.
      ic_rsp_valid_o <= rsp_read && !rsp_owner_dc;
      dc_rsp_valid_o <= (rsp_read && rsp_owner_dc) || rsp_ack;
      dc_rsp_we_o    <= rsp_ack;
      if (rsp_read && !rsp_owner_dc) ic_rsp_rdata_o <= mem_rsp_rdata_i;
      if (rsp_read && rsp_owner_dc)  dc_rsp_rdata_o <= mem_rsp_rdata_i;
      else if (rsp_ack)              dc_rsp_rdata_o <= '0;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: hand-computed expectations per step.
module tb_mem_req_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TID_W  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              ic_req_valid_i;
  logic [ADDR_W-1:0] ic_req_addr_i;
  logic              ic_req_ready_o;
  logic              dc_req_valid_i;
  logic              dc_req_we_i;
  logic              dc_req_nc_i;
  logic [ADDR_W-1:0] dc_req_addr_i;
  logic [DATA_W-1:0] dc_req_wdata_i;
  logic              dc_req_ready_o;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_req_we_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [DATA_W-1:0] mem_req_wdata_o;
  logic [TID_W-1:0]  mem_req_tid_o;
  logic              mem_rsp_valid_i;
  logic              mem_rsp_we_i;
  logic [TID_W-1:0]  mem_rsp_tid_i;
  logic [DATA_W-1:0] mem_rsp_rdata_i;
  logic              ic_rsp_valid_o;
  logic [DATA_W-1:0] ic_rsp_rdata_o;
  logic              dc_rsp_valid_o;
  logic              dc_rsp_we_o;
  logic [DATA_W-1:0] dc_rsp_rdata_o;
  logic [2:0]        stores_pending_o;

  int checks = 0;
  int errors = 0;

  mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TID_W(TID_W), .MAX_STORES(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
    .ic_req_ready_o(ic_req_ready_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_we_i(dc_req_we_i), .dc_req_nc_i(dc_req_nc_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_wdata_i(dc_req_wdata_i),
    .dc_req_ready_o(dc_req_ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_tid_o(mem_req_tid_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_we_i(mem_rsp_we_i),
    .mem_rsp_tid_i(mem_rsp_tid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_rdata_o(ic_rsp_rdata_o),
    .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_we_o(dc_rsp_we_o),
    .dc_rsp_rdata_o(dc_rsp_rdata_o), .stores_pending_o(stores_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic handshake();
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
  endtask

  task automatic send_rsp(input logic we, input logic [TID_W-1:0] tid, input logic [63:0] data);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_we_i    = we;
    mem_rsp_tid_i   = tid;
    mem_rsp_rdata_i = data;
    step();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_we_i    = 1'b0;
    mem_rsp_tid_i   = '0;
    mem_rsp_rdata_i = '0;
  endtask

  task automatic dc_write(input logic [63:0] addr, input logic [63:0] data, input string tag);
    dc_req_valid_i = 1'b1;
    dc_req_we_i    = 1'b1;
    dc_req_nc_i    = 1'b0;
    dc_req_addr_i  = addr;
    dc_req_wdata_i = data;
    #1;
    check({tag, "_ready"}, 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0;
    dc_req_we_i    = 1'b0;
    check({tag, "_wdata"}, mem_req_wdata_o, data);
    handshake();
  endtask

  task automatic ic_read(input logic [63:0] addr, input logic [1:0] exp_tid, input string tag);
    ic_req_valid_i = 1'b1;
    ic_req_addr_i  = addr;
    #1;
    check({tag, "_ready"}, 64'(ic_req_ready_o), 64'd1);
    step();
    ic_req_valid_i = 1'b0;
    check({tag, "_tid"}, 64'(mem_req_tid_o), 64'(exp_tid));
    handshake();
  endtask

  initial begin
    rst_i = 1'b1;
    ic_req_valid_i = 1'b0; ic_req_addr_i = '0;
    dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0; dc_req_nc_i = 1'b0;
    dc_req_addr_i = '0; dc_req_wdata_i = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_we_i = 1'b0; mem_rsp_tid_i = '0; mem_rsp_rdata_i = '0;
    step();
    step();
    check("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_stores", 64'(stores_pending_o), 64'd0);
    check("rst_ic_rsp", 64'(ic_rsp_valid_o), 64'd0);
    check("rst_dc_rsp", 64'(dc_rsp_valid_o), 64'd0);
    check("rst_ic_ready", 64'(ic_req_ready_o), 64'd0);
    rst_i = 1'b0;

    // Simultaneous ic and dc reads: ic first with TID 0, then dc with TID 1.
    ic_req_valid_i = 1'b1; ic_req_addr_i = 64'h1000;
    dc_req_valid_i = 1'b1; dc_req_addr_i = 64'h2000;
    #1;
    check("sim_ic_ready", 64'(ic_req_ready_o), 64'd1);
    check("sim_dc_ready0", 64'(dc_req_ready_o), 64'd0);
    check("sim_mem_valid_pre", 64'(mem_req_valid_o), 64'd0);
    step();
    ic_req_valid_i = 1'b0;
    check("sim_ic_mem_valid", 64'(mem_req_valid_o), 64'd1);
    check("sim_ic_addr", mem_req_addr_o, 64'h1000);
    check("sim_ic_tid", 64'(mem_req_tid_o), 64'd0);
    check("sim_dc_ready_issue", 64'(dc_req_ready_o), 64'd0);
    handshake();
    #1;
    check("sim_mem_valid_drop", 64'(mem_req_valid_o), 64'd0);
    check("sim_dc_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0;
    check("sim_dc_mem_valid", 64'(mem_req_valid_o), 64'd1);
    check("sim_dc_addr", mem_req_addr_o, 64'h2000);
    check("sim_dc_tid", 64'(mem_req_tid_o), 64'd1);
    check("sim_dc_we", 64'(mem_req_we_o), 64'd0);
    handshake();

    // Read responses routed by owner.
    send_rsp(1'b0, 2'd1, 64'hD1D1);
    check("rsp_dc_valid", 64'(dc_rsp_valid_o), 64'd1);
    check("rsp_dc_data", dc_rsp_rdata_o, 64'hD1D1);
    check("rsp_dc_we", 64'(dc_rsp_we_o), 64'd0);
    check("rsp_ic_quiet", 64'(ic_rsp_valid_o), 64'd0);
    send_rsp(1'b0, 2'd0, 64'hC0C0);
    check("rsp_ic_valid", 64'(ic_rsp_valid_o), 64'd1);
    check("rsp_ic_data", ic_rsp_rdata_o, 64'hC0C0);
    check("rsp_dc_quiet", 64'(dc_rsp_valid_o), 64'd0);

    // Bogus responses are dropped.
    send_rsp(1'b0, 2'd2, 64'hBAD);
    check("bogus_rd_ic", 64'(ic_rsp_valid_o), 64'd0);
    check("bogus_rd_dc", 64'(dc_rsp_valid_o), 64'd0);
    send_rsp(1'b1, 2'd0, 64'h0);
    check("bogus_ack_dc", 64'(dc_rsp_valid_o), 64'd0);
    check("bogus_ack_cnt", 64'(stores_pending_o), 64'd0);

    // Store limit: seven writes issue, the eighth waits for an ack.
    for (int i = 0; i < 7; i++) dc_write(64'h3000 + 64'(i * 8), 64'hA0 + 64'(i), "st");
    check("st_cnt7", 64'(stores_pending_o), 64'd7);
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1;
    dc_req_addr_i = 64'h3100; dc_req_wdata_i = 64'hEE;
    #1;
    check("st8_blocked", 64'(dc_req_ready_o), 64'd0);
    step();
    step();
    check("st8_still_blocked", 64'(dc_req_ready_o), 64'd0);
    send_rsp(1'b1, 2'd0, 64'h0);
    check("st_ack_valid", 64'(dc_rsp_valid_o), 64'd1);
    check("st_ack_we", 64'(dc_rsp_we_o), 64'd1);
    check("st_cnt6", 64'(stores_pending_o), 64'd6);
    check("st8_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0;
    check("st8_cnt7", 64'(stores_pending_o), 64'd7);
    check("st8_we", 64'(mem_req_we_o), 64'd1);
    check("st8_addr", mem_req_addr_o, 64'h3100);
    check("st8_tid", 64'(mem_req_tid_o), 64'd0);
    handshake();
    for (int i = 0; i < 5; i++) send_rsp(1'b1, 2'd0, 64'h0);
    check("st_cnt2", 64'(stores_pending_o), 64'd2);

    // Write grant and write ack in the same cycle leave the count unchanged.
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1;
    dc_req_addr_i = 64'h3200; dc_req_wdata_i = 64'h55;
    mem_rsp_valid_i = 1'b1; mem_rsp_we_i = 1'b1;
    #1;
    check("same_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_we_i = 1'b0;
    check("same_cnt", 64'(stores_pending_o), 64'd2);
    handshake();

    // Non-cacheable read drains the two outstanding stores first.
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b0; dc_req_nc_i = 1'b1;
    dc_req_addr_i = 64'h4000;
    #1;
    check("nc_blocked", 64'(dc_req_ready_o), 64'd0);
    step();
    check("nc_drain_blocked", 64'(dc_req_ready_o), 64'd0);
    send_rsp(1'b1, 2'd0, 64'h0);
    check("nc_cnt1", 64'(stores_pending_o), 64'd1);
    check("nc_drain_blocked1", 64'(dc_req_ready_o), 64'd0);
    send_rsp(1'b1, 2'd0, 64'h0);
    check("nc_cnt0", 64'(stores_pending_o), 64'd0);
    check("nc_drain_blocked0", 64'(dc_req_ready_o), 64'd0);
    step();
    check("nc_ready", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0; dc_req_nc_i = 1'b0;
    check("nc_addr", mem_req_addr_o, 64'h4000);
    check("nc_tid", 64'(mem_req_tid_o), 64'd0);
    handshake();

    // TID exhaustion: fill TIDs 1..3, writes still pass, fifth read waits for TID 2.
    ic_read(64'h5001, 2'd1, "ex1");
    ic_read(64'h5002, 2'd2, "ex2");
    ic_read(64'h5003, 2'd3, "ex3");
    dc_write(64'h5100, 64'h77, "exw");
    check("exw_cnt", 64'(stores_pending_o), 64'd1);
    ic_req_valid_i = 1'b1; ic_req_addr_i = 64'h5005;
    #1;
    check("ex5_blocked", 64'(ic_req_ready_o), 64'd0);
    step();
    check("ex5_blocked2", 64'(ic_req_ready_o), 64'd0);
    mem_rsp_valid_i = 1'b1; mem_rsp_tid_i = 2'd2; mem_rsp_rdata_i = 64'h2222;
    #1;
    check("ex5_same_cycle", 64'(ic_req_ready_o), 64'd0);
    step();
    mem_rsp_valid_i = 1'b0; mem_rsp_tid_i = '0; mem_rsp_rdata_i = '0;
    check("ex_rsp_ic", 64'(ic_rsp_valid_o), 64'd1);
    check("ex_rsp_data", ic_rsp_rdata_o, 64'h2222);
    check("ex5_ready", 64'(ic_req_ready_o), 64'd1);
    step();
    ic_req_valid_i = 1'b0;
    check("ex5_tid", 64'(mem_req_tid_o), 64'd2);

    // Back-pressure: payload stays put, no further accepts while in ISSUE.
    dc_req_valid_i = 1'b1; dc_req_we_i = 1'b1;
    dc_req_addr_i = 64'h6000; dc_req_wdata_i = 64'h66;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 64'(mem_req_valid_o), 64'd1);
      check("bp_addr", mem_req_addr_o, 64'h5005);
      check("bp_tid", 64'(mem_req_tid_o), 64'd2);
      check("bp_dc_ready", 64'(dc_req_ready_o), 64'd0);
    end
    handshake();
    check("bp_dc_ready_after", 64'(dc_req_ready_o), 64'd1);
    step();
    dc_req_valid_i = 1'b0; dc_req_we_i = 1'b0;
    check("bp_cnt", 64'(stores_pending_o), 64'd2);
    check("bp_w_addr", mem_req_addr_o, 64'h6000);

    // Reset mid-ISSUE abandons the request; stale responses are dropped afterwards.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mr_valid", 64'(mem_req_valid_o), 64'd0);
    check("mr_cnt", 64'(stores_pending_o), 64'd0);
    send_rsp(1'b0, 2'd1, 64'h1111);
    check("mr_stale_rd_ic", 64'(ic_rsp_valid_o), 64'd0);
    check("mr_stale_rd_dc", 64'(dc_rsp_valid_o), 64'd0);
    send_rsp(1'b1, 2'd0, 64'h0);
    check("mr_stale_ack", 64'(dc_rsp_valid_o), 64'd0);
    check("mr_stale_cnt", 64'(stores_pending_o), 64'd0);
    ic_read(64'h7000, 2'd0, "mr_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
